input_debouncer: RTL



---
 rtl/input_debouncer_if.sv | 21 ++
 rtl/input_debouncer.sv | 119 +++++++++++
 2 files changed

// File: rtl/input_debouncer_if.sv
// Pin-side and register-file-side signals of the input debouncer.
// The slave modport is the debouncer; the master modport is the pin/consumer side.
interface input_debouncer_if;
    logic [15:0] SW_raw;
    logic        BTNR_raw;
    logic [15:0] switches;
    logic        BTNR;
    logic        btn_press;
    logic        btn_release;
    logic [7:0]  btn_count;

    modport master (
        output SW_raw, BTNR_raw,
        input  switches, BTNR, btn_press, btn_release, btn_count
    );

    modport slave (
        input  SW_raw, BTNR_raw,
        output switches, BTNR, btn_press, btn_release, btn_count
    );
endinterface

// File: rtl/input_debouncer.sv
// Synchronises and debounces 16 slide switches (one shared counter) and the right button.
// Optional press counter on btn_count is enabled by defining BTN_PRESS_COUNT_EN.
module input_debouncer #(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned CNT_W           = 20
) (
    input  logic                clock,
    input  logic                ctrl_reset,
    input_debouncer_if.slave    bus
);
    localparam int unsigned SW_W       = 16;
    localparam int unsigned BTN_CNT_W  = 8;
    localparam int unsigned CNT_LAST   = DEBOUNCE_CYCLES - 1;

    logic [SYNC_STAGES-1:0][SW_W-1:0] r_sw_sync;
    logic [SYNC_STAGES-1:0]           r_btn_sync;
    logic [SW_W-1:0]                  w_sw_synced;
    logic                             w_btn_synced;

    logic [SW_W-1:0]  r_sw_stable, r_sw_prev, w_sw_stable_nxt;
    logic [CNT_W-1:0] r_sw_cnt, w_sw_cnt_nxt;
    logic             r_btn_stable, r_btn_prev, w_btn_stable_nxt;
    logic [CNT_W-1:0] r_btn_cnt, w_btn_cnt_nxt;
    logic             r_btn_press, r_btn_release, w_press_nxt, w_release_nxt;

    // Metastability chain; stage 0 samples the pin.
    always_ff @(posedge clock) begin
        if (ctrl_reset) begin
            r_sw_sync  <= '0;
            r_btn_sync <= '0;
        end else begin
            r_sw_sync  <= {r_sw_sync[SYNC_STAGES-2:0], bus.SW_raw};
            r_btn_sync <= {r_btn_sync[SYNC_STAGES-2:0], bus.BTNR_raw};
        end
    end

    assign w_sw_synced  = r_sw_sync[SYNC_STAGES-1];
    assign w_btn_synced = r_btn_sync[SYNC_STAGES-1];

    // Switch channel: any bit moving restarts the whole vector.
    always_comb begin
        w_sw_stable_nxt = r_sw_stable;
        w_sw_cnt_nxt    = '0;
        if (w_sw_synced == r_sw_stable) begin
            w_sw_cnt_nxt = '0;
        end else if (w_sw_synced != r_sw_prev) begin
            w_sw_cnt_nxt = '0;
        end else if (r_sw_cnt == CNT_W'(CNT_LAST)) begin
            w_sw_stable_nxt = w_sw_synced;
            w_sw_cnt_nxt    = '0;
        end else begin
            w_sw_cnt_nxt = r_sw_cnt + CNT_W'(1);
        end
    end

    // Button channel plus edge detection on the debounced level.
    always_comb begin
        w_btn_stable_nxt = r_btn_stable;
        w_btn_cnt_nxt    = '0;
        if (w_btn_synced == r_btn_stable) begin
            w_btn_cnt_nxt = '0;
        end else if (w_btn_synced != r_btn_prev) begin
            w_btn_cnt_nxt = '0;
        end else if (r_btn_cnt == CNT_W'(CNT_LAST)) begin
            w_btn_stable_nxt = w_btn_synced;
            w_btn_cnt_nxt    = '0;
        end else begin
            w_btn_cnt_nxt = r_btn_cnt + CNT_W'(1);
        end
        w_press_nxt   = ~r_btn_stable &  w_btn_stable_nxt;
        w_release_nxt =  r_btn_stable & ~w_btn_stable_nxt;
    end

    always_ff @(posedge clock) begin
        if (ctrl_reset) begin
            r_sw_stable   <= '0;
            r_sw_prev     <= '0;
            r_sw_cnt      <= '0;
            r_btn_stable  <= 1'b0;
            r_btn_prev    <= 1'b0;
            r_btn_cnt     <= '0;
            r_btn_press   <= 1'b0;
            r_btn_release <= 1'b0;
        end else begin
            r_sw_stable   <= w_sw_stable_nxt;
            r_sw_prev     <= w_sw_synced;
            r_sw_cnt      <= w_sw_cnt_nxt;
            r_btn_stable  <= w_btn_stable_nxt;
            r_btn_prev    <= w_btn_synced;
            r_btn_cnt     <= w_btn_cnt_nxt;
            r_btn_press   <= w_press_nxt;
            r_btn_release <= w_release_nxt;
        end
    end

`ifdef BTN_PRESS_COUNT_EN
    logic [BTN_CNT_W-1:0] r_btn_count;

    // Counts on the same edge the press pulse is set; wraps naturally.
    always_ff @(posedge clock) begin
        if (ctrl_reset) begin
            r_btn_count <= '0;
        end else if (w_press_nxt) begin
            r_btn_count <= r_btn_count + BTN_CNT_W'(1);
        end
    end

    assign bus.btn_count = r_btn_count;
`else
    assign bus.btn_count = BTN_CNT_W'(0);
`endif

    assign bus.switches    = r_sw_stable;
    assign bus.BTNR        = r_btn_stable;
    assign bus.btn_press   = r_btn_press;
    assign bus.btn_release = r_btn_release;

endmodule
